// File: rtl/key_click_decoder_pkg.sv
// Shared constants and types for the key click decoder: window defaults,
// FSM state type and the event bundle.
package key_click_decoder_pkg;

    localparam int unsigned CNT_WIN_W = 25;
    localparam int unsigned CLICK_W   = 2;

    // 500 ms at 50 MHz; the debouncer's 20 ms CNT_MAX sits beside it so key_top sets both here.
    localparam logic [CNT_WIN_W-1:0] CNT_WIN_DEFAULT     = 25'd25_000_000;
    localparam logic [19:0]          KEY_CNT_MAX_DEFAULT = 20'd999_999;

    localparam logic [CLICK_W-1:0] CLICKS_ONE = 2'd1;
    localparam logic [CLICK_W-1:0] CLICKS_TWO = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_WAIT = 2'b10
    } click_state_e;

    typedef struct packed {
        logic single_click;
        logic double_click;
        logic triple_click;
    } click_event_t;

    // Event emitted when the window closes with the given number of clicks.
    function automatic click_event_t expiry_event(input logic [CLICK_W-1:0] clicks);
        click_event_t ev;
        ev              = '0;
        ev.single_click = (clicks == CLICKS_ONE);
        ev.double_click = (clicks == CLICKS_TWO);
        return ev;
    endfunction

endpackage

// File: rtl/key_click_decoder_if.sv
// Click-decoder signal bundle: debounced key pulse in, click events and status out.
interface key_click_decoder_if;
    import key_click_decoder_pkg::*;

    logic               key_flag;
    logic               single_click;
    logic               double_click;
    logic               triple_click;
    logic [CLICK_W-1:0] click_cnt;
    logic               busy;

    modport master (
        output key_flag,
        input  single_click,
        input  double_click,
        input  triple_click,
        input  click_cnt,
        input  busy
    );

    modport slave (
        input  key_flag,
        output single_click,
        output double_click,
        output triple_click,
        output click_cnt,
        output busy
    );

endinterface

// File: rtl/key_click_decoder.sv
// Groups debounced key presses into single/double/triple click events using
// an inter-click window timer; every output is registered.
module key_click_decoder
    import key_click_decoder_pkg::*;
#(
    parameter logic [CNT_WIN_W-1:0] CNT_WIN = CNT_WIN_DEFAULT
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    key_click_decoder_if.slave    kc
);

    localparam logic [CNT_WIN_W-1:0] WIN_LAST = CNT_WIN - CNT_WIN_W'(1);

    click_state_e         state_q,     state_d;
    logic [CNT_WIN_W-1:0] cnt_win_q,   cnt_win_d;
    logic [CLICK_W-1:0]   click_cnt_q, click_cnt_d;
    click_event_t         event_q,     event_d;

    always_comb begin
        state_d     = state_q;
        cnt_win_d   = cnt_win_q;
        click_cnt_d = click_cnt_q;
        event_d     = '0;

        case (state_q)
            ST_IDLE: begin
                cnt_win_d   = '0;
                click_cnt_d = '0;
                if (kc.key_flag) begin
                    state_d     = ST_WAIT;
                    click_cnt_d = CLICKS_ONE;
                end
            end

            ST_WAIT: begin
                // key_flag is tested before expiry so a click on the last window cycle still counts.
                if (kc.key_flag) begin
                    cnt_win_d = '0;
                    if (click_cnt_q == CLICKS_TWO) begin
                        event_d.triple_click = 1'b1;
                        state_d              = ST_IDLE;
                        click_cnt_d          = '0;
                    end else begin
                        click_cnt_d = click_cnt_q + CLICK_W'(1);
                    end
                end else if (cnt_win_q == WIN_LAST) begin
                    event_d     = expiry_event(click_cnt_q);
                    state_d     = ST_IDLE;
                    cnt_win_d   = '0;
                    click_cnt_d = '0;
                end else begin
                    cnt_win_d = cnt_win_q + CNT_WIN_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cnt_win_d   = '0;
                click_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_win_q   <= '0;
            click_cnt_q <= '0;
            event_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_win_q   <= cnt_win_d;
            click_cnt_q <= click_cnt_d;
            event_q     <= event_d;
        end
    end

    assign kc.single_click = event_q.single_click;
    assign kc.double_click = event_q.double_click;
    assign kc.triple_click = event_q.triple_click;
    assign kc.click_cnt    = click_cnt_q;
    assign kc.busy         = (state_q == ST_WAIT);

endmodule

// File: tb/tb_key_click_decoder.sv
// Bench for key_click_decoder with CNT_WIN = 20: directed click scenarios plus
// random key traffic against a timestamp-based reference model.
module tb_key_click_decoder;

    localparam logic [24:0] CNT_WIN = 25'd20;
    localparam int          WIN     = 20;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    key_click_decoder_if kif();

    key_click_decoder #(.CNT_WIN(CNT_WIN)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .kc        (kif)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;
    int c        = 0;

    // Reference model: an open sequence is a click count plus the time of the last click.
    bit         m_open = 1'b0;
    int         m_n    = 0;
    int         m_last = 0;
    logic [5:0] exp_v  = '0;

    function automatic logic [5:0] dut_v();
        return {kif.single_click, kif.double_click, kif.triple_click, kif.busy, kif.click_cnt};
    endfunction

    task automatic step(input bit kf);
        bit s, d, t;
        s = 0; d = 0; t = 0;
        kif.key_flag = kf;
        if (!sys_rst_n) begin
            m_open = 0;
            m_n    = 0;
        end else if (kf) begin
            if (m_open && m_n == 2) begin
                t = 1; m_open = 0; m_n = 0;
            end else if (m_open) begin
                m_n = m_n + 1; m_last = c;
            end else begin
                m_open = 1; m_n = 1; m_last = c;
            end
        end else if (m_open && (c - m_last) == WIN) begin
            s = (m_n == 1);
            d = (m_n == 2);
            m_open = 0; m_n = 0;
        end
        exp_v = {s, d, t, m_open, m_open ? 2'(m_n) : 2'd0};
        @(posedge sys_clk);
        #1;
        c++;
    endtask

    task automatic do_reset();
        kif.key_flag = 1'b0;
        sys_rst_n    = 1'b0;
        m_open = 0; m_n = 0; exp_v = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        c = 0;
    endtask

    task automatic test_reset();
        kif.key_flag = 1'b0;
        sys_rst_n    = 1'b0;
        #1;
        checks++;
        if (dut_v() !== 6'b0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", dut_v(), 6'b0);
        end
        kif.key_flag = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if (dut_v() !== 6'b0) begin
            failures++;
            $display("FAIL reset_hold_with_key got=%b exp=%b", dut_v(), 6'b0);
        end
        do_reset();
        checks++;
        if (dut_v() !== 6'b0) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", dut_v(), 6'b0);
        end
    endtask

    task automatic test_single();
        int n_ev = 0, ev_c = -1;
        bit busy_ok = 1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(c == 5);
            checks++;
            if (dut_v() !== exp_v) begin
                failures++;
                $display("FAIL single_model cyc=%0d got=%b exp=%b", c, dut_v(), exp_v);
            end
            if (kif.single_click) begin n_ev++; ev_c = c; end
            if (kif.busy !== ((c >= 6 && c <= 25) ? 1'b1 : 1'b0)) busy_ok = 0;
        end
        checks++;
        if (n_ev != 1 || ev_c != 26) begin
            failures++;
            $display("FAIL single_event count=%0d cyc=%0d exp_count=1 exp_cyc=26", n_ev, ev_c);
        end
        checks++;
        if (!busy_ok) begin
            failures++;
            $display("FAIL single_busy_window got=0 exp=1 (busy only in cycles 6..25)");
        end
    endtask

    task automatic test_double();
        int n_ev = 0, ev_c = -1;
        bit cnt_ok = 1;
        do_reset();
        for (int i = 0; i < 45; i++) begin
            step(c == 5 || c == 15);
            checks++;
            if (dut_v() !== exp_v) begin
                failures++;
                $display("FAIL double_model cyc=%0d got=%b exp=%b", c, dut_v(), exp_v);
            end
            if (kif.double_click) begin n_ev++; ev_c = c; end
            if (c >= 16 && c <= 35 && kif.click_cnt !== 2'd2) cnt_ok = 0;
            if (c == 36 && kif.click_cnt !== 2'd0) cnt_ok = 0;
        end
        checks++;
        if (n_ev != 1 || ev_c != 36) begin
            failures++;
            $display("FAIL double_event count=%0d cyc=%0d exp_count=1 exp_cyc=36", n_ev, ev_c);
        end
        checks++;
        if (!cnt_ok) begin
            failures++;
            $display("FAIL double_click_cnt got=0 exp=1 (cnt 2 in 16..35, 0 at 36)");
        end
    endtask

    task automatic test_triple();
        int n_ev = 0, ev_c = -1;
        logic busy16 = 1'bx;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            step(c == 5 || c == 10 || c == 15);
            checks++;
            if (dut_v() !== exp_v) begin
                failures++;
                $display("FAIL triple_model cyc=%0d got=%b exp=%b", c, dut_v(), exp_v);
            end
            if (kif.single_click || kif.double_click || kif.triple_click) n_ev++;
            if (kif.triple_click) ev_c = c;
            if (c == 16) busy16 = kif.busy;
        end
        checks++;
        if (n_ev != 1 || ev_c != 16) begin
            failures++;
            $display("FAIL triple_event count=%0d cyc=%0d exp_count=1 exp_cyc=16", n_ev, ev_c);
        end
        checks++;
        if (busy16 !== 1'b0) begin
            failures++;
            $display("FAIL triple_busy got=%b exp=0", busy16);
        end
    endtask

    task automatic test_boundary();
        int n_single = 0, n_double = 0, ev_c = -1;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step(c == 5 || c == 25);
            checks++;
            if (dut_v() !== exp_v) begin
                failures++;
                $display("FAIL boundary_model cyc=%0d got=%b exp=%b", c, dut_v(), exp_v);
            end
            if (kif.single_click) n_single++;
            if (kif.double_click) begin n_double++; ev_c = c; end
        end
        checks++;
        if (n_single != 0 || n_double != 1 || ev_c != 46) begin
            failures++;
            $display("FAIL boundary_event singles=%0d doubles=%0d cyc=%0d exp=0/1/46", n_single, n_double, ev_c);
        end
    endtask

    task automatic test_back_to_back();
        int ev[$];
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step(c == 5 || c == 26);
            checks++;
            if (dut_v() !== exp_v) begin
                failures++;
                $display("FAIL b2b_model cyc=%0d got=%b exp=%b", c, dut_v(), exp_v);
            end
            if (kif.single_click) ev.push_back(c);
        end
        checks++;
        if (ev.size() != 2 || ev[0] != 26 || ev[1] != 47) begin
            failures++;
            $display("FAIL b2b_events count=%0d first=%0d second=%0d exp=2/26/47",
                     ev.size(), (ev.size() > 0) ? ev[0] : -1, (ev.size() > 1) ? ev[1] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int n_ev = 0;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            if (c == 12) begin
                sys_rst_n = 1'b0;
                #1;
                checks++;
                if (dut_v() !== 6'b0) begin
                    failures++;
                    $display("FAIL reset_mid_immediate got=%b exp=%b", dut_v(), 6'b0);
                end
            end
            if (c == 14) sys_rst_n = 1'b1;
            step(c == 5 || c == 10);
            checks++;
            if (dut_v() !== exp_v) begin
                failures++;
                $display("FAIL reset_mid_model cyc=%0d got=%b exp=%b", c, dut_v(), exp_v);
            end
            if (kif.single_click || kif.double_click || kif.triple_click) n_ev++;
        end
        checks++;
        if (n_ev != 0) begin
            failures++;
            $display("FAIL reset_mid_events got=%0d exp=0", n_ev);
        end
    endtask

    task automatic test_random();
        int p = 5;
        bit kf;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) p = $urandom_range(1, 20);
            kf = ($urandom_range(0, 99) < p);
            if (m_open && (c - m_last) == WIN && $urandom_range(0, 1) == 1) kf = 1;
            step(kf);
            checks++;
            if (dut_v() !== exp_v) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%b exp=%b", c, dut_v(), exp_v);
            end
        end
    endtask

    initial begin
        kif.key_flag = 1'b0;
        test_reset();
        test_single();
        test_double();
        test_triple();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
